icache_l2_responder: RTL and testbench

ICACHE_L2_RESPONDER -- requirements
Module: icache_l2_responder

---
 rtl/icache_l2_responder.sv | 137 +++++++++++++
 tb/tb_icache_l2_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_l2_responder.sv
// L2-side responder for an instruction cache: serves L1 fetch bursts from the L2 SRAM,
// handles core sleep/launch, and returns words through a 2-entry flow-through FIFO.
module icache_l2_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_info,
  output logic        fetch_gnt,
  output logic        fetch_r_valid,
  output logic [31:0] fetch_r_data,
  input  logic        fetch_r_ready,
  output logic        mem_cs,
  output logic [18:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        launch_req,
  input  logic [18:0] launch_addr,
  output logic        launch_gnt,
  output logic        core_sleeping,
  output logic        sleep_pulse
);

  typedef enum logic [1:0] {SLEEP = 2'd0, IDLE = 2'd1, READ = 2'd2} state_e;

  state_e      state_q;
  logic [31:0] fifo_data_q [2];
  logic [1:0]  fifo_tag_q;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  occ_q;
  logic [1:0]  occ_d;
  logic        rvld_q;
  logic [18:0] base_q;
  logic [3:0]  count_q;
  logic [3:0]  issued_q;
  logic [3:0]  done_q;
  logic        sleep_pulse_q;

  logic        fifo_empty;
  logic        bypass;
  logic        head_tag;
  logic        pop;
  logic        pop_stored;
  logic        push_mem;
  logic        push;
  logic [31:0] push_data;
  logic        push_tag;
  logic        sleep_cmd;
  logic [3:0]  req_count;
  logic [1:0]  used;
  logic        burst_pop;
  logic        last_beat;
  logic        unused_info;

  assign unused_info = ^fetch_info[30:21];

  // A word arriving from SRAM into an empty FIFO is presented the same cycle, so a burst
  // streams at one word per cycle; it is stored only if L1 does not take it.
  assign fifo_empty    = (occ_q == 2'd0);
  assign bypass        = fifo_empty & rvld_q;
  assign fetch_r_valid = ~fifo_empty | rvld_q;
  assign fetch_r_data  = bypass ? mem_rdata : fifo_data_q[rd_ptr_q];
  assign head_tag      = bypass | fifo_tag_q[rd_ptr_q];
  assign pop           = fetch_r_valid & fetch_r_ready;
  assign pop_stored    = pop & ~fifo_empty;
  assign push_mem      = rvld_q & ~(bypass & fetch_r_ready);

  assign launch_gnt = (state_q == SLEEP) & launch_req & fifo_empty;
  assign push       = push_mem | launch_gnt;
  assign push_data  = launch_gnt ? {13'b0, launch_addr} : mem_rdata;
  assign push_tag   = ~launch_gnt;
  assign occ_d      = occ_q + {1'b0, push} - {1'b0, pop_stored};

  assign fetch_gnt = (state_q == IDLE) & fetch_req;
  assign sleep_cmd = fetch_info[31];
  assign req_count = fetch_info[20] ? 4'd1 : (fetch_info[19] ? 4'd8 : 4'd4);

  // Stored words plus the read in flight never exceed the FIFO depth.
  assign used     = occ_q + {1'b0, rvld_q};
  assign mem_cs   = (state_q == READ) & (issued_q < count_q) & (used < 2'd2);
  assign mem_addr = base_q + 19'(issued_q);

  // Tag bit separates burst words from a leftover launch word still queued ahead of them.
  assign burst_pop = pop & head_tag & (state_q == READ);
  assign last_beat = burst_pop & ((done_q + 4'd1) == count_q);

  assign core_sleeping = (state_q == SLEEP);
  assign sleep_pulse   = sleep_pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SLEEP;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_tag_q     <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= '0;
      rvld_q         <= 1'b0;
      base_q         <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      done_q         <= '0;
      sleep_pulse_q  <= 1'b0;
    end else begin
      rvld_q        <= mem_cs;
      sleep_pulse_q <= fetch_gnt & sleep_cmd;
      occ_q         <= occ_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_tag_q[wr_ptr_q]  <= push_tag;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_stored) rd_ptr_q <= ~rd_ptr_q;
      if (mem_cs)     issued_q <= issued_q + 4'd1;
      if (burst_pop)  done_q   <= done_q + 4'd1;
      case (state_q)
        SLEEP: if (launch_gnt) state_q <= IDLE;
        IDLE: begin
          if (fetch_gnt) begin
            if (sleep_cmd) begin
              state_q <= SLEEP;
            end else begin
              state_q  <= READ;
              base_q   <= fetch_info[18:0];
              count_q  <= req_count;
              issued_q <= '0;
              done_q   <= '0;
            end
          end
        end
        READ:    if (last_beat) state_q <= IDLE;
        default: state_q <= SLEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_l2_responder.sv
// Bench for icache_l2_responder: directed scenarios plus randomized traffic, scored
// against a transaction-level model of expected return words and SRAM addresses.
module tb_icache_l2_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_info;
  logic        fetch_gnt;
  logic        fetch_r_valid;
  logic [31:0] fetch_r_data;
  logic        fetch_r_ready;
  logic        mem_cs;
  logic [18:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        launch_req;
  logic [18:0] launch_addr;
  logic        launch_gnt;
  logic        core_sleeping;
  logic        sleep_pulse;

  always #5 clk = ~clk;

  icache_l2_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_info    (fetch_info),
    .fetch_gnt     (fetch_gnt),
    .fetch_r_valid (fetch_r_valid),
    .fetch_r_data  (fetch_r_data),
    .fetch_r_ready (fetch_r_ready),
    .mem_cs        (mem_cs),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .launch_req    (launch_req),
    .launch_addr   (launch_addr),
    .launch_gnt    (launch_gnt),
    .core_sleeping (core_sleeping),
    .sleep_pulse   (sleep_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: words owed to L1 in order, SRAM addresses still to be read.
  logic [31:0] expq [$];
  bit          tagq [$];
  int          addrq [$];
  bit          m_sleep;
  int          m_rem;
  bit          m_pulse;
  bit          pend_vld;
  logic [18:0] pend_addr;
  bit          prev_v;
  bit          prev_r;
  logic [31:0] prev_d;
  int          rdy_mode;
  int          rdy_idx;
  bit          last_efg;
  bit          last_elg;
  bit          obs_fg;
  bit          obs_lg;
  bit          obs_sp;
  bit          obs_cs;
  bit          obs_v;
  logic [31:0] obs_d;
  int          grant_cyc;
  int          beat_cyc [$];
  int          cap_addr [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [18:0] a);
    return ({13'b0, a} * 32'd2654435761) ^ 32'hA5A50000;
  endfunction

  task automatic model_reset();
    expq.delete();
    tagq.delete();
    addrq.delete();
    m_sleep  = 1'b1;
    m_rem    = 0;
    m_pulse  = 1'b0;
    pend_vld = 1'b0;
    prev_v   = 1'b0;
    prev_r   = 1'b0;
  endtask

  task automatic chk_rst();
    chk("rst_fetch_gnt", fetch_gnt, 0);
    chk("rst_r_valid", fetch_r_valid, 0);
    chk("rst_r_data", fetch_r_data, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_launch_gnt", launch_gnt, 0);
    chk("rst_core_sleeping", core_sleeping, 1);
    chk("rst_sleep_pulse", sleep_pulse, 0);
  endtask

  // One clock cycle: entered and left at posedge+1, outputs judged at the negedge.
  task automatic tick();
    bit efg;
    bit elg;
    int occ_words;
    int cnt;
    int base;
    case (rdy_mode)
      0: fetch_r_ready = 1'b1;
      1: begin
        fetch_r_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
        rdy_idx++;
      end
      default: fetch_r_ready = ($urandom_range(0, 9) < 6);
    endcase
    mem_rdata = pend_vld ? memf(pend_addr) : $urandom();
    @(negedge clk);
    efg = fetch_req && !m_sleep && (m_rem == 0);
    elg = launch_req && m_sleep && (expq.size() == 0);
    chk("fetch_gnt", fetch_gnt, efg);
    chk("launch_gnt", launch_gnt, elg);
    chk("core_sleeping", core_sleeping, m_sleep);
    chk("sleep_pulse", sleep_pulse, m_pulse);
    obs_fg = fetch_gnt;
    obs_lg = launch_gnt;
    obs_sp = sleep_pulse;
    obs_cs = core_sleeping;
    obs_v  = fetch_r_valid;
    obs_d  = fetch_r_data;
    if (prev_v && !prev_r) begin
      chk("hold_valid", fetch_r_valid, 1);
      chk("hold_data", fetch_r_data, prev_d);
    end
    pend_vld = 1'b0;
    if (mem_cs) begin
      occ_words = expq.size() - addrq.size();
      chk("mem_cs_room", occ_words, (occ_words > 1) ? 1 : occ_words);
      if (addrq.size() == 0) chk("mem_cs_extra", addrq.size(), 1);
      else chk("mem_addr", mem_addr, addrq.pop_front());
      pend_vld  = 1'b1;
      pend_addr = mem_addr;
      cap_addr.push_back(int'(mem_addr));
    end
    if (fetch_r_valid && fetch_r_ready) begin
      beat_cyc.push_back(cyc);
      if (expq.size() == 0) chk("beat_extra", expq.size(), 1);
      else begin
        chk("beat_data", fetch_r_data, expq.pop_front());
        if (tagq.pop_front()) m_rem--;
      end
    end
    m_pulse = 1'b0;
    if (elg) begin
      expq.push_back({13'b0, launch_addr});
      tagq.push_back(1'b0);
      m_sleep = 1'b0;
    end
    if (efg) begin
      grant_cyc = cyc;
      if (fetch_info[31]) begin
        m_sleep = 1'b1;
        m_pulse = 1'b1;
      end else begin
        cnt   = fetch_info[20] ? 1 : (fetch_info[19] ? 8 : 4);
        base  = int'(fetch_info[18:0]);
        m_rem = cnt;
        for (int i = 0; i < cnt; i++) begin
          addrq.push_back((base + i) % 524288);
          expq.push_back(memf(19'((base + i) % 524288)));
          tagq.push_back(1'b1);
        end
      end
    end
    last_efg = efg;
    last_elg = elg;
    prev_v = fetch_r_valid;
    prev_r = fetch_r_ready;
    prev_d = fetch_r_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_req(input logic [31:0] info);
    bit g = 1'b0;
    fetch_req  = 1'b1;
    fetch_info = info;
    for (int i = 0; i < 300 && !g; i++) begin
      tick();
      g = last_efg;
    end
    fetch_req  = 1'b0;
    fetch_info = $urandom();
    chk("req_granted", g, 1);
  endtask

  task automatic do_launch(input logic [18:0] addr);
    bit g = 1'b0;
    launch_req  = 1'b1;
    launch_addr = addr;
    for (int i = 0; i < 300 && !g; i++) begin
      tick();
      g = last_elg;
    end
    launch_req = 1'b0;
    chk("launch_granted", g, 1);
  endtask

  task automatic drain();
    int i = 0;
    while (i < 400 && (m_rem != 0 || expq.size() != 0)) begin
      tick();
      i++;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g8;
    int last8;
    int ng;
    int nv;
    int k;
    logic [18:0] a;
    bit b20;
    bit b19;
    rst_n = 1'b0;
    fetch_req = 1'b0;
    fetch_info = '0;
    fetch_r_ready = 1'b0;
    mem_rdata = '0;
    launch_req = 1'b0;
    launch_addr = '0;
    rdy_mode = 0;
    rdy_idx = 0;
    grant_cyc = 0;
    last8 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_rst();
    rst_n = 1'b1;

    // Launch from reset
    launch_req  = 1'b1;
    launch_addr = 19'h01234;
    tick();
    chk("launch_gnt_now", obs_lg, 1);
    launch_req = 1'b0;
    tick();
    chk("launch_word_valid", obs_v, 1);
    chk("launch_word_data", obs_d, 32'h00001234);
    chk("launch_awake", obs_cs, 0);
    drain();

    // 8-word burst, full-rate return, immediate regrant
    beat_cyc.delete();
    cap_addr.delete();
    do_req(32'h00080100);
    g8 = grant_cyc;
    drain();
    chk("b8_beats", beat_cyc.size(), 8);
    chk("b8_reads", cap_addr.size(), 8);
    if (beat_cyc.size() == 8) begin
      chk("b8_first_lat", beat_cyc[0] - g8, 2);
      chk("b8_last_lat", beat_cyc[7] - g8, 9);
      last8 = beat_cyc[7];
    end
    if (cap_addr.size() == 8) begin
      chk("b8_addr_first", cap_addr[0], 32'h100);
      chk("b8_addr_last", cap_addr[7], 32'h107);
    end
    do_req(32'h00040200);
    chk("regrant_gap", grant_cyc - last8, 1);
    drain();

    // Single fetch at top of memory, then a wrapping burst of 4
    beat_cyc.delete();
    cap_addr.delete();
    do_req(32'h0017FFFF);
    drain();
    chk("single_reads", cap_addr.size(), 1);
    chk("single_beats", beat_cyc.size(), 1);
    if (cap_addr.size() == 1) chk("single_addr", cap_addr[0], 32'h7FFFF);
    cap_addr.delete();
    do_req(32'h0007FFFE);
    drain();
    chk("wrap_reads", cap_addr.size(), 4);
    if (cap_addr.size() == 4) begin
      chk("wrap_addr2", cap_addr[2], 32'h0);
      chk("wrap_addr3", cap_addr[3], 32'h1);
    end

    // Backpressure with ready pattern 1-0-0-1
    beat_cyc.delete();
    rdy_mode = 1;
    rdy_idx  = 0;
    do_req(32'h00000480);
    drain();
    chk("bp_beats", beat_cyc.size(), 4);
    rdy_mode = 0;

    // Sleep command; held fetch request must wait for a new launch
    do_req(32'h80000000);
    tick();
    chk("sleep_pulse_seen", obs_sp, 1);
    chk("sleep_state", obs_cs, 1);
    fetch_req  = 1'b1;
    fetch_info = 32'h00100040;
    ng = 0;
    repeat (6) begin
      tick();
      ng += int'(obs_fg);
    end
    chk("sleep_no_grant", ng, 0);
    launch_req  = 1'b1;
    launch_addr = 19'h2A5A5;
    tick();
    chk("relaunch_gnt", obs_lg, 1);
    launch_req = 1'b0;
    do_req(32'h00100040);
    drain();

    // Sleep command and launch request in the same IDLE cycle
    fetch_req   = 1'b1;
    fetch_info  = 32'h80000000;
    launch_req  = 1'b1;
    launch_addr = 19'h00ABC;
    tick();
    chk("same_fgnt", obs_fg, 1);
    chk("same_lgnt", obs_lg, 0);
    fetch_req = 1'b0;
    tick();
    chk("same_lgnt_next", obs_lg, 1);
    launch_req = 1'b0;
    drain();

    // Reset during the third word of an 8-word burst
    beat_cyc.delete();
    do_req(32'h00080300);
    k = 0;
    while (beat_cyc.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("pre_rst_beats", beat_cyc.size(), 2);
    rst_n = 1'b0;
    fetch_r_ready = 1'b1;
    #1;
    chk_rst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    nv = 0;
    repeat (8) begin
      tick();
      nv += int'(obs_v);
    end
    chk("post_rst_beats", nv, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      rdy_mode = $urandom_range(0, 2);
      rdy_idx  = 0;
      if (m_sleep) begin
        do_launch(19'($urandom()));
      end else if ($urandom_range(0, 9) == 0) begin
        do_req(32'h80000000 | ($urandom() & 32'h001FFFFF));
      end else begin
        a   = ($urandom_range(0, 3) == 0) ? (19'h7FFF8 + 19'($urandom_range(0, 7))) : 19'($urandom());
        b20 = ($urandom_range(0, 3) == 0);
        b19 = 1'($urandom_range(0, 1));
        do_req({11'b0, b20, b19, a});
      end
    end
    rdy_mode = 0;
    drain();
    chk("final_reads_left", addrq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
